// File: rtl/bg_rot_ref_tracker.sv
// Affine reference point tracker for the rotation/scaling BGs.
// Each BG lane keeps a programmed (latched) and a running reference per axis.

module bg_rot_ref_lane #(
  parameter int REF_W  = 28,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              x_wr,
  input  logic              y_wr,
  input  logic [REF_W-1:0]  x_in,
  input  logic [REF_W-1:0]  y_in,
  input  logic [STEP_W-1:0] pb,
  input  logic [STEP_W-1:0] pd,
  input  logic              step,
  input  logic              reload,
  output logic [REF_W-1:0]  int_x,
  output logic [REF_W-1:0]  int_y
);
  logic [REF_W-1:0] lat_x, lat_y;
  logic [REF_W-1:0] pb_ext, pd_ext;

  assign pb_ext = {{(REF_W-STEP_W){pb[STEP_W-1]}}, pb};
  assign pd_ext = {{(REF_W-STEP_W){pd[STEP_W-1]}}, pd};

  // Priority: CPU write beats frame reload beats line step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_x <= '0;
      lat_y <= '0;
      int_x <= '0;
      int_y <= '0;
    end else begin
      if (x_wr) lat_x <= x_in;
      if (y_wr) lat_y <= y_in;
      if (x_wr)        int_x <= x_in;
      else if (reload) int_x <= lat_x;
      else if (step)   int_x <= int_x + pb_ext;
      if (y_wr)        int_y <= y_in;
      else if (reload) int_y <= lat_y;
      else if (step)   int_y <= int_y + pd_ext;
    end
  end
endmodule

module bg_rot_ref_tracker #(
  parameter int NUM_ROT_BG  = 2,
  parameter int REF_W       = 28,
  parameter int STEP_W      = 16,
  parameter int V_LINES     = 160,
  parameter int TOTAL_LINES = 228,
  localparam int SEL_W      = (NUM_ROT_BG > 1) ? $clog2(NUM_ROT_BG) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         line_end,
  input  logic [NUM_ROT_BG-1:0]        ref_x_wr,
  input  logic [NUM_ROT_BG-1:0]        ref_y_wr,
  input  logic [NUM_ROT_BG*REF_W-1:0]  ref_x_in,
  input  logic [NUM_ROT_BG*REF_W-1:0]  ref_y_in,
  input  logic [NUM_ROT_BG*STEP_W-1:0] step_pb,
  input  logic [NUM_ROT_BG*STEP_W-1:0] step_pd,
  input  logic [NUM_ROT_BG-1:0]        rot_en,
  input  logic [SEL_W-1:0]             bg_sel,
  output logic [REF_W-1:0]             cur_x,
  output logic [REF_W-1:0]             cur_y,
  output logic [7:0]                   line_no,
  output logic                         vblank,
  output logic                         frame_start
);
  localparam logic [7:0] V_LAST = 8'(V_LINES - 1);
  localparam logic [7:0] T_LAST = 8'(TOTAL_LINES - 1);

  typedef enum logic {ACTIVE, VBLANK} state_t;
  state_t     state, state_nxt;
  logic [7:0] line_nxt;
  logic       wrap;
  logic       step_en;

  logic [NUM_ROT_BG-1:0][REF_W-1:0] int_x, int_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACTIVE;
      line_no     <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      line_no     <= line_nxt;
      frame_start <= wrap;
    end
  end

  always_comb begin
    state_nxt = state;
    line_nxt  = line_no;
    wrap      = 1'b0;
    step_en   = 1'b0;
    if (line_end) begin
      line_nxt = (line_no == T_LAST) ? 8'd0 : line_no + 8'd1;
      case (state)
        ACTIVE: begin
          step_en = 1'b1;
          if (line_no == V_LAST) state_nxt = VBLANK;
        end
        VBLANK: begin
          if (line_no == T_LAST) begin
            state_nxt = ACTIVE;
            wrap      = 1'b1;
          end
        end
        default: state_nxt = ACTIVE;
      endcase
    end
  end

  assign vblank = (state == VBLANK);

  for (genvar g = 0; g < NUM_ROT_BG; g++) begin : g_lane
    bg_rot_ref_lane #(.REF_W(REF_W), .STEP_W(STEP_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .x_wr   (ref_x_wr[g]),
      .y_wr   (ref_y_wr[g]),
      .x_in   (ref_x_in[g*REF_W +: REF_W]),
      .y_in   (ref_y_in[g*REF_W +: REF_W]),
      .pb     (step_pb[g*STEP_W +: STEP_W]),
      .pd     (step_pd[g*STEP_W +: STEP_W]),
      .step   (step_en & rot_en[g]),
      .reload (wrap),
      .int_x  (int_x[g]),
      .int_y  (int_y[g])
    );
  end

  // Out-of-range selects fall back to BG0.
  always_comb begin
    cur_x = int_x[0];
    cur_y = int_y[0];
    for (int i = 1; i < NUM_ROT_BG; i++) begin
      if (bg_sel == SEL_W'(i)) begin
        cur_x = int_x[i];
        cur_y = int_y[i];
      end
    end
  end
endmodule

// File: tb/tb_bg_rot_ref_tracker.sv
// Randomized and directed bench for bg_rot_ref_tracker against a line-level reference model.
module tb_bg_rot_ref_tracker;
  localparam int NB = 2, RW = 28, SW = 16, VL = 160, TL = 228;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           line_end;
  logic [NB-1:0]  ref_x_wr, ref_y_wr, rot_en;
  logic [NB*RW-1:0] ref_x_in, ref_y_in;
  logic [NB*SW-1:0] step_pb, step_pd;
  logic           bg_sel;
  logic [RW-1:0]  cur_x, cur_y;
  logic [7:0]     line_no;
  logic           vblank, frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [RW-1:0] m_lat_x[NB], m_lat_y[NB], m_int_x[NB], m_int_y[NB];
  int            m_line;
  bit            m_fs;

  bg_rot_ref_tracker dut (
    .clk(clk), .rst_n(rst_n), .line_end(line_end),
    .ref_x_wr(ref_x_wr), .ref_y_wr(ref_y_wr),
    .ref_x_in(ref_x_in), .ref_y_in(ref_y_in),
    .step_pb(step_pb), .step_pd(step_pd),
    .rot_en(rot_en), .bg_sel(bg_sel),
    .cur_x(cur_x), .cur_y(cur_y), .line_no(line_no),
    .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] add_step(input logic [RW-1:0] r, input logic [SW-1:0] s);
    longint sum;
    sum = longint'(r) + longint'($signed(s));
    sum = sum & ((64'd1 << RW) - 1);
    return sum[RW-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_lat_x[i] = '0; m_lat_y[i] = '0; m_int_x[i] = '0; m_int_y[i] = '0;
    end
    m_line = 0;
    m_fs   = 0;
  endtask

  // One clock edge with the currently driven inputs; model follows, strobes then clear.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NB; i++) begin
      if (ref_x_wr[i]) begin
        m_lat_x[i] = ref_x_in[i*RW +: RW];
        m_int_x[i] = ref_x_in[i*RW +: RW];
      end else if (line_end && m_line == TL-1) m_int_x[i] = m_lat_x[i];
      else if (line_end && m_line < VL && rot_en[i]) m_int_x[i] = add_step(m_int_x[i], step_pb[i*SW +: SW]);
      if (ref_y_wr[i]) begin
        m_lat_y[i] = ref_y_in[i*RW +: RW];
        m_int_y[i] = ref_y_in[i*RW +: RW];
      end else if (line_end && m_line == TL-1) m_int_y[i] = m_lat_y[i];
      else if (line_end && m_line < VL && rot_en[i]) m_int_y[i] = add_step(m_int_y[i], step_pd[i*SW +: SW]);
    end
    m_fs = line_end && (m_line == TL-1);
    if (line_end) m_line = (m_line + 1) % TL;
    #1;
    line_end = 0; ref_x_wr = '0; ref_y_wr = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    n_checks += 5;
    if (cur_x !== '0)       begin n_fail++; $display("FAIL reset_cur_x got %h want 0", cur_x); end
    if (cur_y !== '0)       begin n_fail++; $display("FAIL reset_cur_y got %h want 0", cur_y); end
    if (line_no !== 8'd0)   begin n_fail++; $display("FAIL reset_line_no got %0d want 0", line_no); end
    if (vblank !== 1'b0)    begin n_fail++; $display("FAIL reset_vblank got %b want 0", vblank); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    @(negedge clk); rst_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_basic_step();
    bg_sel = 0; rot_en = 2'b01;
    step_pb[0 +: SW] = 16'h0100; step_pd[0 +: SW] = 16'h0080;
    ref_x_in[0 +: RW] = 28'h0000100; ref_x_wr = 2'b01;
    tick();
    n_checks++;
    if (cur_x !== 28'h0000100) begin n_fail++; $display("FAIL write_visible got %h want 0000100", cur_x); end
    repeat (3) begin line_end = 1; tick(); end
    n_checks += 2;
    if (cur_x !== 28'h0000400) begin n_fail++; $display("FAIL step3_x got %h want 0000400", cur_x); end
    if (cur_y !== m_int_y[0])  begin n_fail++; $display("FAIL step3_y got %h want %h", cur_y, m_int_y[0]); end
  endtask

  task automatic test_neg_wrap();
    step_pb[0 +: SW] = 16'hFF00;
    ref_x_in[0 +: RW] = 28'h0000080; ref_x_wr = 2'b01; tick();
    line_end = 1; tick();
    n_checks++;
    if (cur_x !== m_int_x[0]) begin n_fail++; $display("FAIL neg_wrap got %h want %h", cur_x, m_int_x[0]); end
  endtask

  task automatic test_frame();
    int fs_seen = 0;
    int guard = 0;
    step_pb[0 +: SW] = 16'h0123; step_pd[0 +: SW] = 16'hFE10;
    ref_x_in[0 +: RW] = 28'h0ABCDEF; ref_y_in[0 +: RW] = 28'h0F00000;
    ref_x_wr = 2'b01; ref_y_wr = 2'b01; tick();
    while (guard < 4*TL) begin
      guard++;
      line_end = ($urandom_range(0, 3) != 0);
      tick();
      n_checks += 4;
      if (line_no !== 8'(m_line)) begin n_fail++; $display("FAIL frame_line got %0d want %0d", line_no, m_line); end
      if (vblank !== (m_line >= VL)) begin n_fail++; $display("FAIL frame_vblank line %0d got %b", m_line, vblank); end
      if (frame_start !== m_fs) begin n_fail++; $display("FAIL frame_start got %b want %b", frame_start, m_fs); end
      if (cur_x !== m_int_x[0]) begin n_fail++; $display("FAIL frame_x got %h want %h", cur_x, m_int_x[0]); end
      if (m_fs) begin
        fs_seen++;
        n_checks++;
        if (cur_y !== m_lat_y[0]) begin n_fail++; $display("FAIL reload_y got %h want %h", cur_y, m_lat_y[0]); end
        break;
      end
    end
    n_checks++;
    if (fs_seen != 1) begin n_fail++; $display("FAIL frame_wrap_seen got %0d want 1", fs_seen); end
  endtask

  task automatic test_collision();
    // write with step
    ref_x_in[0 +: RW] = 28'h1234567; ref_x_wr = 2'b01; line_end = 1; tick();
    n_checks++;
    if (cur_x !== 28'h1234567) begin n_fail++; $display("FAIL write_vs_step got %h want 1234567", cur_x); end
    // write with reload on the wrap line; BG1 unwritten must reload
    while (m_line != TL-1) begin line_end = 1; tick(); end
    ref_y_in[0 +: RW] = 28'h0765432; ref_y_wr = 2'b01; line_end = 1; tick();
    n_checks += 3;
    if (cur_y !== 28'h0765432) begin n_fail++; $display("FAIL write_vs_reload got %h want 0765432", cur_y); end
    if (frame_start !== 1'b1)  begin n_fail++; $display("FAIL collision_fs got %b want 1", frame_start); end
    bg_sel = 1; #1;
    if (cur_x !== m_int_x[1])  begin n_fail++; $display("FAIL reload_bg3 got %h want %h", cur_x, m_int_x[1]); end
    bg_sel = 0;
  endtask

  task automatic test_rot_en();
    logic [RW-1:0] x3;
    ref_x_in = {28'h0333000, 28'h0222000}; ref_x_wr = 2'b11;
    step_pb = {16'h0777, 16'h0040}; rot_en = 2'b01; tick();
    x3 = ref_x_in[RW +: RW];
    repeat (5) begin line_end = 1; tick(); end
    bg_sel = 1; #1;
    n_checks += 2;
    if (cur_x !== x3) begin n_fail++; $display("FAIL bg3_hold got %h want %h", cur_x, x3); end
    bg_sel = 0; #1;
    if (cur_x !== m_int_x[0]) begin n_fail++; $display("FAIL bg2_advance got %h want %h", cur_x, m_int_x[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      line_end = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NB; i++) begin
        ref_x_wr[i] = ($urandom_range(0, 9) == 0);
        ref_y_wr[i] = ($urandom_range(0, 9) == 0);
        ref_x_in[i*RW +: RW] = RW'($urandom);
        ref_y_in[i*RW +: RW] = RW'($urandom);
      end
      if ($urandom_range(0, 31) == 0) begin
        step_pb = {$urandom, $urandom}; step_pd = {$urandom, $urandom};
        rot_en  = 2'($urandom);
      end
      tick();
      bg_sel = 1'($urandom); #1;
      n_checks += 5;
      if (cur_x !== m_int_x[bg_sel]) begin n_fail++; $display("FAIL rand_x c%0d got %h want %h", c, cur_x, m_int_x[bg_sel]); end
      if (cur_y !== m_int_y[bg_sel]) begin n_fail++; $display("FAIL rand_y c%0d got %h want %h", c, cur_y, m_int_y[bg_sel]); end
      if (line_no !== 8'(m_line)) begin n_fail++; $display("FAIL rand_line c%0d got %0d want %0d", c, line_no, m_line); end
      if (vblank !== (m_line >= VL)) begin n_fail++; $display("FAIL rand_vblank c%0d got %b", c, vblank); end
      if (frame_start !== m_fs) begin n_fail++; $display("FAIL rand_fs c%0d got %b want %b", c, frame_start, m_fs); end
    end
  endtask

  task automatic test_async_reset();
    rot_en = 2'b11;
    while (m_line != 80) begin line_end = 1; tick(); end
    line_end = 1;
    #2 rst_n = 0;
    #1;
    n_checks += 4;
    if (cur_x !== '0 || cur_y !== '0) begin n_fail++; $display("FAIL areset_cur got %h/%h want 0", cur_x, cur_y); end
    if (line_no !== 8'd0) begin n_fail++; $display("FAIL areset_line got %0d want 0", line_no); end
    if (vblank !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL areset_flags got %b%b want 00", vblank, frame_start); end
    @(posedge clk); #1;
    if (line_no !== 8'd0) begin n_fail++; $display("FAIL areset_hold got %0d want 0", line_no); end
    line_end = 0;
    @(negedge clk); rst_n = 1;
    model_reset();
    bg_sel = 1;
    step_pb[RW > 0 ? SW : 0 +: SW] = 16'h0200;
    ref_x_in[RW +: RW] = 28'h0001000; ref_x_wr = 2'b10; tick();
    repeat (2) begin line_end = 1; tick(); end
    n_checks += 2;
    if (cur_x !== m_int_x[1]) begin n_fail++; $display("FAIL resume_x got %h want %h", cur_x, m_int_x[1]); end
    if (line_no !== 8'd2) begin n_fail++; $display("FAIL resume_line got %0d want 2", line_no); end
  endtask

  initial begin
    line_end = 0; ref_x_wr = '0; ref_y_wr = '0; rot_en = '0; bg_sel = 0;
    ref_x_in = '0; ref_y_in = '0; step_pb = '0; step_pd = '0;
    model_reset();
    test_reset();
    test_basic_step();
    test_neg_wrap();
    test_frame();
    test_collision();
    test_rot_en();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
